// File: rtl/ce_sequencer.sv
// ce_sequencer: run-control scheduler producing the clk_enable strobe for a
// generated subsystem. Modes: idle, continuous run, single step, counted burst.
//
// Handshake: run_req/stop_req/step_req/burst_req are single-cycle pulses with
// no backpressure. A request is accepted on the edge it is sampled only if the
// current mode allows it (priority stop > step > burst > run); otherwise it is
// dropped. busy tells the requester that a mode other than IDLE is active, and
// done marks normal completion of a STEP or BURST.
module ce_sequencer #(
  parameter int DIV_MAX = 1199999,
  parameter int DIV_W   = 21,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_req,
  input  logic               stop_req,
  input  logic               step_req,
  input  logic               burst_req,
  input  logic [BURST_W-1:0] burst_len,
  output logic               ce,
  output logic [1:0]         state,
  output logic               done,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BURST = 2'b11
  } state_t;

  localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(DIV_MAX);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [BURST_W-1:0] cnt_inc;
  logic               ce_q, ce_d;
  logic               done_q, done_d;
  logic               wrap;

  assign wrap    = (div_q == DIV_TOP);
  assign cnt_inc = cnt_q + BURST_W'(1);

  // Next-state, divider/pulse counters and registered strobe decisions.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ce_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (stop_req) begin
          state_d = S_IDLE;
        end else if (step_req) begin
          state_d = S_STEP;
        end else if (burst_req) begin
          len_d = burst_len;
          cnt_d = '0;
          // A zero-length burst completes immediately without any enable.
          if (burst_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_BURST;
          end
        end else if (run_req) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Stop wins over a coinciding wrap: no enable on the stop edge.
        if (stop_req) begin
          state_d = S_IDLE;
        end else if (wrap) begin
          ce_d = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_STEP: begin
        state_d = S_IDLE;
        if (!stop_req) begin
          ce_d   = 1'b1;
          done_d = 1'b1;
        end
      end
      S_BURST: begin
        if (stop_req) begin
          state_d = S_IDLE;
        end else if (wrap) begin
          ce_d  = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ce_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ce_q    <= ce_d;
      done_q  <= done_d;
    end
  end

  assign ce    = ce_q;
  assign done  = done_q;
  assign state = state_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_ce_sequencer.sv
// tb_ce_sequencer: directed table-driven bench for ce_sequencer with P = 4.
module tb_ce_sequencer;

  localparam int DIV_MAX = 3;
  localparam int DIV_W   = 4;
  localparam int BURST_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_STEP  = 2'b10;
  localparam logic [1:0] ST_BURST = 2'b11;

  logic               clk;
  logic               rst_n;
  logic               run_req;
  logic               stop_req;
  logic               step_req;
  logic               burst_req;
  logic [BURST_W-1:0] burst_len;
  logic               ce;
  logic [1:0]         state;
  logic               done;
  logic               busy;

  int n_checks;
  int n_bad;

  typedef struct {
    logic               run;
    logic               stop;
    logic               step;
    logic               burst;
    logic [BURST_W-1:0] len;
    logic               exp_ce;
    logic               exp_done;
    logic [1:0]         exp_st;
  } vec_t;

  vec_t vecs[$];

  ce_sequencer #(
    .DIV_MAX(DIV_MAX),
    .DIV_W  (DIV_W),
    .BURST_W(BURST_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_req  (run_req),
    .stop_req (stop_req),
    .step_req (step_req),
    .burst_req(burst_req),
    .burst_len(burst_len),
    .ce       (ce),
    .state    (state),
    .done     (done),
    .busy     (busy)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s idx=%0d got=%0h exp=%0h t=%0t", name, idx, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input int idx, input logic e_ce, input logic e_done, input logic [1:0] e_st);
    check({tag, ".ce"},    idx, {3'b0, ce},   {3'b0, e_ce});
    check({tag, ".done"},  idx, {3'b0, done}, {3'b0, e_done});
    check({tag, ".state"}, idx, {2'b0, state}, {2'b0, e_st});
    check({tag, ".busy"},  idx, {3'b0, busy}, {3'b0, (e_st != ST_IDLE)});
  endtask

  // Driver helpers.
  task automatic drive(input logic r, input logic s, input logic st, input logic b, input logic [BURST_W-1:0] l);
    run_req   = r;
    stop_req  = s;
    step_req  = st;
    burst_req = b;
    burst_len = l;
  endtask

  task automatic add(input logic r, input logic s, input logic st, input logic b, input logic [BURST_W-1:0] l,
                     input logic e_ce, input logic e_done, input logic [1:0] e_st);
    vec_t v;
    v.run = r; v.stop = s; v.step = st; v.burst = b; v.len = l;
    v.exp_ce = e_ce; v.exp_done = e_done; v.exp_st = e_st;
    vecs.push_back(v);
  endtask

  task automatic add_idle(input logic e_ce, input logic e_done, input logic [1:0] e_st);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, e_ce, e_done, e_st);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Reset held, then 20 quiet cycles.
    repeat (3) @(posedge clk);
    #1;
    check_outputs("rst_hold", 0, 1'b0, 1'b0, ST_IDLE);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_outputs("quiet", i, 1'b0, 1'b0, ST_IDLE);
    end

    // Run, with ignored step/burst/run requests, stopped on a wrap edge.
    add(1, 0, 0, 0, 0, 0, 0, ST_RUN);
    add_idle(0, 0, ST_RUN);
    add(0, 0, 1, 1, 2, 0, 0, ST_RUN);
    add_idle(0, 0, ST_RUN);
    add_idle(1, 0, ST_RUN);
    for (int i = 0; i < 3; i++) add_idle(0, 0, ST_RUN);
    add(1, 0, 0, 0, 0, 1, 0, ST_RUN);
    for (int i = 0; i < 3; i++) add_idle(0, 0, ST_RUN);
    add(0, 1, 0, 0, 0, 0, 0, ST_IDLE);
    add_idle(0, 0, ST_IDLE);

    // Step; step during STEP ignored; step issued in the done cycle; stop in STEP.
    add(0, 0, 1, 0, 0, 0, 0, ST_STEP);
    add(0, 0, 1, 0, 0, 1, 1, ST_IDLE);
    add(0, 0, 1, 0, 0, 0, 0, ST_STEP);
    add_idle(1, 1, ST_IDLE);
    add_idle(0, 0, ST_IDLE);
    add(0, 0, 1, 0, 0, 0, 0, ST_STEP);
    add(0, 1, 0, 0, 0, 0, 0, ST_IDLE);
    add_idle(0, 0, ST_IDLE);

    // Burst of 3, then back-to-back zero-length burst.
    add(0, 0, 0, 1, 3, 0, 0, ST_BURST);
    add_idle(0, 0, ST_BURST);
    add(1, 0, 0, 0, 0, 0, 0, ST_BURST);
    add_idle(0, 0, ST_BURST);
    add_idle(1, 0, ST_BURST);
    for (int i = 0; i < 3; i++) add_idle(0, 0, ST_BURST);
    add_idle(1, 0, ST_BURST);
    for (int i = 0; i < 3; i++) add_idle(0, 0, ST_BURST);
    add_idle(1, 1, ST_IDLE);
    add(0, 0, 0, 1, 0, 0, 1, ST_IDLE);
    add_idle(0, 0, ST_IDLE);

    // Burst of 5 aborted by stop after two pulses.
    add(0, 0, 0, 1, 5, 0, 0, ST_BURST);
    for (int i = 0; i < 3; i++) add_idle(0, 0, ST_BURST);
    add_idle(1, 0, ST_BURST);
    for (int i = 0; i < 3; i++) add_idle(0, 0, ST_BURST);
    add_idle(1, 0, ST_BURST);
    add(0, 1, 0, 0, 0, 0, 0, ST_IDLE);
    add_idle(0, 0, ST_IDLE);

    // Priority: stop+run, step+burst+run, burst(len 1)+run.
    add(1, 1, 0, 0, 0, 0, 0, ST_IDLE);
    add_idle(0, 0, ST_IDLE);
    add(1, 0, 1, 1, 2, 0, 0, ST_STEP);
    add_idle(1, 1, ST_IDLE);
    add(1, 0, 0, 1, 1, 0, 0, ST_BURST);
    for (int i = 0; i < 3; i++) add_idle(0, 0, ST_BURST);
    add_idle(1, 1, ST_IDLE);
    add_idle(0, 0, ST_IDLE);

    foreach (vecs[i]) begin
      drive(vecs[i].run, vecs[i].stop, vecs[i].step, vecs[i].burst, vecs[i].len);
      tick();
      check_outputs("vec", i, vecs[i].exp_ce, vecs[i].exp_done, vecs[i].exp_st);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Asynchronous reset mid-burst while ce is high.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (4) tick();
    check_outputs("pre_rst", 0, 1'b1, 1'b0, ST_BURST);
    #3 rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 0, 1'b0, 1'b0, ST_IDLE);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_outputs("post_rst", i, 1'b0, 1'b0, ST_IDLE);
    end

    // First run after reset: enable exactly P cycles after acceptance.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check_outputs("run_rst", 0, 1'b0, 1'b0, ST_RUN);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_outputs("run_rst", i, (i == 4), 1'b0, ST_RUN);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
